// File: rtl/multibyte_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// multibyte_add_sequencer_if
//   Bundles the three signal groups of the multibyte add sequencer:
//     - request channel  (in_*)  : valid/ready, operands, carry-in, sub select
//     - adder channel    (add_*) : one byte per cycle to/from an external
//                                  8-bit ripple-carry adder
//     - result channel   (out_*) : valid/ready, full sum, carry-out, overflow
//   Modports:
//     slave  : the sequencer itself (consumes requests, drives the adder,
//              produces results)
//     master : the environment (issues requests, provides the adder,
//              consumes results)
// ---------------------------------------------------------------------------
interface multibyte_add_sequencer_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    // request channel
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;

    // adder channel
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic         add_cin;
    logic [7:0]   add_sum;
    logic         add_cout;

    // result channel
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub,
        input  add_sum, add_cout,
        input  out_ready,
        output in_ready,
        output add_a, add_b, add_cin,
        output out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub,
        output add_sum, add_cout,
        output out_ready,
        input  in_ready,
        input  add_a, add_b, add_cin,
        input  out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/multibyte_add_sequencer.sv
// ---------------------------------------------------------------------------
// multibyte_add_sequencer
//   Drives an external 8-bit ripple-carry adder byte-serially to perform one
//   NBYTES*8-bit add or subtract per request. Operand bytes are presented LSB
//   first; the adder's carry is registered and fed back as the next byte's
//   carry-in. Subtraction is A + ~B + ~borrow_in, so the final carry is
//   "no borrow".
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset, aborts any operation in flight
//   bus    : multibyte_add_sequencer_if.slave
//              in_*   request handshake (in_valid/in_ready, in_a, in_b,
//                     in_cin, in_sub)
//              add_*  adder feed (add_a, add_b, add_cin out; add_sum,
//                     add_cout in, combinational from add_*)
//              out_*  result handshake (out_valid/out_ready, out_sum,
//                     out_cout, out_ovf)
//
// Timing: out_valid rises NBYTES cycles after the accept edge and holds,
// together with the result, until out_ready is seen.
// ---------------------------------------------------------------------------
module multibyte_add_sequencer #(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multibyte_add_sequencer_if.slave bus
);
    localparam int W  = 8 * NBYTES;
    localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_sh;
    logic [W-1:0]  b_sh;
    logic [W-1:0]  res;
    logic          carry;
    logic          ovf;
    logic [CW-1:0] cnt;

    // Signed overflow of the most significant byte: both addends share a sign
    // and the sum's sign differs from it. b is already inverted for subtract,
    // so the same rule covers both operations.
    function automatic logic byte_ovf(input logic signed [7:0] a,
                                      input logic signed [7:0] b,
                                      input logic signed [7:0] s);
        return (a[7] == b[7]) && (s[7] != a[7]);
    endfunction

    // New sum byte enters at the top; after NBYTES shifts the result is
    // aligned. Done via a wide concat + shift so NBYTES=1 needs no special
    // slice.
    logic [W+7:0] res_cat;
    logic [W-1:0] res_next;
    assign res_cat  = {bus.add_sum, res} >> 8;
    assign res_next = res_cat[W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_sh  <= bus.in_a;
                        b_sh  <= bus.in_sub ? ~bus.in_b : bus.in_b;
                        // borrow-in becomes an inverted carry-in
                        carry <= bus.in_sub ^ bus.in_cin;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    res   <= res_next;
                    carry <= bus.add_cout;
                    a_sh  <= a_sh >> 8;
                    b_sh  <= b_sh >> 8;
                    if (cnt == LAST) begin
                        ovf   <= byte_ovf(a_sh[7:0], b_sh[7:0], bus.add_sum);
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state and datapath registers, so they are
    // glitch-free and stable while DONE is held.
    always_comb begin
        bus.in_ready  = (state == IDLE);
        bus.add_a     = 8'd0;
        bus.add_b     = 8'd0;
        bus.add_cin   = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_sum   = '0;
        bus.out_cout  = 1'b0;
        bus.out_ovf   = 1'b0;
        if (state == RUN) begin
            bus.add_a   = a_sh[7:0];
            bus.add_b   = b_sh[7:0];
            bus.add_cin = carry;
        end
        if (state == DONE) begin
            bus.out_valid = 1'b1;
            bus.out_sum   = res;
            bus.out_cout  = carry;
            bus.out_ovf   = ovf;
        end
    end
endmodule

// File: tb/tb_multibyte_add_sequencer.sv
module tb_multibyte_add_sequencer;
    localparam int NBYTES = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    multibyte_add_sequencer_if #(.NBYTES(NBYTES)) bus ();

    multibyte_add_sequencer #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // 8-bit ripple-carry adder the sequencer is wrapped around
    assign {bus.add_cout, bus.add_sum} =
        {1'b0, bus.add_a} + {1'b0, bus.add_b} + {8'd0, bus.add_cin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, expect the result NBYTES edges after acceptance,
    // then consume it.
    task automatic run_op(input string name, input vec_t v);
        int lat;
        chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = v.a;
        bus.in_b     = v.b;
        bus.in_cin   = v.cin;
        bus.in_sub   = v.sub;
        tick();
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_cin   = 1'($urandom);
        bus.in_sub   = 1'($urandom);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk({name, "_latency"}, 32'(lat), 32'(NBYTES));
        chk({name, "_sum"},  bus.out_sum, v.sum);
        chk({name, "_cout"}, 32'(bus.out_cout), 32'(v.cout));
        chk({name, "_ovf"},  32'(bus.out_ovf), 32'(v.ovf));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({name, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    logic [31:0] held_sum;
    logic        held_cout;
    logic        held_ovf;
    int          lat;

    initial begin
        checks = 0;
        errors = 0;
        //          a             b             cin   sub   sum           cout  ovf
        vecs[0] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[3] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
        vecs[4] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        vecs[7] = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.in_sub    = 1'b0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;

        // reset state
        #12;
        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_sum",   bus.out_sum, 32'd0);
        chk("rst_add_a",     32'(bus.add_a), 32'd0);
        chk("rst_add_b",     32'(bus.add_b), 32'd0);
        chk("rst_add_cin",   32'(bus.add_cin), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // table-driven vectors
        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i]);
        end

        // backpressure in DONE with in_valid pulsing
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h12345678;
        bus.in_b     = 32'h11111111;
        bus.in_cin   = 1'b0;
        bus.in_sub   = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("hold_latency", 32'(lat), 32'(NBYTES));
        held_sum  = bus.out_sum;
        held_cout = bus.out_cout;
        held_ovf  = bus.out_ovf;
        chk("hold_sum0", held_sum, 32'h23456789);
        for (int k = 0; k < 3; k++) begin
            bus.in_valid = (k != 1);
            bus.in_a     = 32'hDEADBEEF;
            bus.in_b     = 32'h0BADF00D;
            tick();
            chk($sformatf("hold%0d_valid", k), 32'(bus.out_valid), 32'd1);
            chk($sformatf("hold%0d_sum", k),   bus.out_sum, 32'h23456789);
            chk($sformatf("hold%0d_cout", k),  32'(bus.out_cout), 32'(held_cout));
            chk($sformatf("hold%0d_ovf", k),   32'(bus.out_ovf), 32'(held_ovf));
            chk($sformatf("hold%0d_in_ready", k), 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("hold_release_valid", 32'(bus.out_valid), 32'd0);
        chk("hold_release_ready", 32'(bus.in_ready), 32'd1);
        run_op("after_hold", vecs[5]);

        // reset in the middle of RUN
        bus.in_valid = 1'b1;
        bus.in_a     = 32'h12345678;
        bus.in_b     = 32'h11111111;
        bus.in_cin   = 1'b0;
        bus.in_sub   = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("mid_add_a",   32'(bus.add_a), 32'h34);
        chk("mid_add_b",   32'(bus.add_b), 32'h11);
        chk("mid_add_cin", 32'(bus.add_cin), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_add_a",     32'(bus.add_a), 32'd0);
        chk("abort_add_b",     32'(bus.add_b), 32'd0);
        chk("abort_add_cin",   32'(bus.add_cin), 32'd0);
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_out_sum",   bus.out_sum, 32'd0);
        chk("abort_out_cout",  32'(bus.out_cout), 32'd0);
        chk("abort_out_ovf",   32'(bus.out_ovf), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("abort_no_valid%0d", k), 32'(bus.out_valid), 32'd0);
        end
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        run_op("rerun_t1", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
